// File: rtl/uart_ctrl_pkg.sv
// Shared register map, STATUS bit positions and FSM state types for the UART FIFO controller.
// Imported by the controller top and its FIFO sub-module.
package uart_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_BAUD_LO = 2'd2;
  localparam logic [1:0] ADDR_BAUD_HI = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_TX_OVF   = 5;

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT,
    T_RELEASE
  } tx_state_t;

  typedef enum logic {
    R_IDLE,
    R_ACK
  } rx_state_t;

endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Single-clock FIFO with combinational head; zero-latency dout, push ignored when full, pop ignored when empty.
// A full FIFO refuses a push even if a pop lands in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly AW bits, so power-of-two DEPTH wraps for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// CPU register front-end for the UART engine: TX/RX byte FIFOs, start/done and available/clear handshakes, baud divisor.
// DATA write launches one cycle after it lands; RX is flow-controlled by withholding rx_clear while the RX FIFO is full.
module uart_fifo_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [11:0] RESET_BAUD = 12'd51
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        irq,
  output logic        start_tx,
  output logic [7:0]  tx_value,
  input  logic        tx_done,
  input  logic        rx_available,
  input  logic [7:0]  rx_value,
  output logic        rx_clear,
  output logic [11:0] uart_baud_counter
);

  tx_state_t   tx_state_q, tx_state_d;
  rx_state_t   rx_state_q, rx_state_d;
  logic        start_tx_q, start_tx_d;
  logic [7:0]  tx_value_q, tx_value_d;
  logic        rx_clear_q, rx_clear_d;
  logic        tx_overflow_q, tx_overflow_d;
  logic [11:0] baud_q, baud_d;

  logic       wr_data, wr_status, wr_baud_lo, wr_baud_hi, rd_data;
  logic       tx_pop, rx_push;
  logic [7:0] tx_head, rx_head;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] status;

  assign wr_data    = wr_en && (addr == ADDR_DATA);
  assign wr_status  = wr_en && (addr == ADDR_STATUS);
  assign wr_baud_lo = wr_en && (addr == ADDR_BAUD_LO);
  assign wr_baud_hi = wr_en && (addr == ADDR_BAUD_HI);
  assign rd_data    = rd_en && (addr == ADDR_DATA);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (tx_pop),
    .din   (wdata),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rd_data),
    .din   (rx_value),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // The byte leaves the FIFO at launch, so tx_empty can read 1 while it is still on the wire.
  always_comb begin
    tx_state_d = tx_state_q;
    start_tx_d = start_tx_q;
    tx_value_d = tx_value_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty) begin
          tx_value_d = tx_head;
          tx_pop     = 1'b1;
          start_tx_d = 1'b1;
          tx_state_d = T_WAIT;
        end
      end
      T_WAIT: begin
        if (tx_done) begin
          start_tx_d = 1'b0;
          tx_state_d = T_RELEASE;
        end
      end
      T_RELEASE: begin
        if (!tx_done) begin
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // A full RX FIFO simply withholds the acknowledge; the engine keeps presenting its byte.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_clear_d = rx_clear_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_available && !rx_full) begin
          rx_push    = 1'b1;
          rx_clear_d = 1'b1;
          rx_state_d = R_ACK;
        end
      end
      R_ACK: begin
        if (!rx_available) begin
          rx_clear_d = 1'b0;
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Set is evaluated after clear so a simultaneous overflow is never lost.
  always_comb begin
    tx_overflow_d = tx_overflow_q;
    if (wr_status && wdata[ST_TX_OVF]) begin
      tx_overflow_d = 1'b0;
    end
    if (wr_data && tx_full) begin
      tx_overflow_d = 1'b1;
    end
  end

  always_comb begin
    baud_d = baud_q;
    if (wr_baud_lo) begin
      baud_d[7:0] = wdata;
    end
    if (wr_baud_hi) begin
      baud_d[11:8] = wdata[3:0];
    end
  end

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_BUSY]  = (tx_state_q != T_IDLE);
    status[ST_TX_OVF]   = tx_overflow_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:    rdata = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS:  rdata = status;
      ADDR_BAUD_LO: rdata = baud_q[7:0];
      ADDR_BAUD_HI: rdata = {4'h0, baud_q[11:8]};
      default:      rdata = '0;
    endcase
  end

  assign irq               = !rx_empty;
  assign start_tx          = start_tx_q;
  assign tx_value          = tx_value_q;
  assign rx_clear          = rx_clear_q;
  assign uart_baud_counter = baud_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q    <= T_IDLE;
      rx_state_q    <= R_IDLE;
      start_tx_q    <= 1'b0;
      tx_value_q    <= '0;
      rx_clear_q    <= 1'b0;
      tx_overflow_q <= 1'b0;
      baud_q        <= RESET_BAUD;
    end else begin
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      start_tx_q    <= start_tx_d;
      tx_value_q    <= tx_value_d;
      rx_clear_q    <= rx_clear_d;
      tx_overflow_q <= tx_overflow_d;
      baud_q        <= baud_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
// Bench-side engine models answer start_tx after 20 cycles and present RX bytes from a source queue.
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        irq;
  logic        start_tx;
  logic [7:0]  tx_value;
  logic        tx_done = 1'b0;
  logic        rx_available = 1'b0;
  logic [7:0]  rx_value = '0;
  logic        rx_clear;
  logic [11:0] uart_baud_counter;

  int checks = 0;
  int errors = 0;

  uart_fifo_ctrl #(.DEPTH(DEPTH), .RESET_BAUD(12'd51)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .wr_en             (wr_en),
    .rd_en             (rd_en),
    .wdata             (wdata),
    .rdata             (rdata),
    .irq               (irq),
    .start_tx          (start_tx),
    .tx_value          (tx_value),
    .tx_done           (tx_done),
    .rx_available      (rx_available),
    .rx_value          (rx_value),
    .rx_clear          (rx_clear),
    .uart_baud_counter (uart_baud_counter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  bit          m_ovf = 1'b0;
  logic [11:0] m_baud = 12'd51;
  int          m_phase = 0;   // 0 idle, 1 waiting for done, 2 waiting for done to drop
  logic [7:0]  m_txv = '0;
  bit          m_ack = 1'b0;

  always @(posedge clk) begin : model_p
    int txn, rxn;
    logic [7:0] e_rd;
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_ovf   = 1'b0;
      m_baud  = 12'd51;
      m_phase = 0;
      m_txv   = '0;
      m_ack   = 1'b0;
    end else begin
      txn = m_txq.size();
      rxn = m_rxq.size();
      if (m_phase == 0 && txn > 0) begin
        m_txv   = m_txq.pop_front();
        m_phase = 1;
      end else if (m_phase == 1 && tx_done) begin
        m_phase = 2;
      end else if (m_phase == 2 && !tx_done) begin
        m_phase = 0;
      end
      if (wr_en && addr == 2'd1 && wdata[5]) m_ovf = 1'b0;
      if (wr_en && addr == 2'd0) begin
        if (txn < DEPTH) m_txq.push_back(wdata);
        else m_ovf = 1'b1;
      end
      if (rd_en && addr == 2'd0 && rxn > 0) m_rxq.delete(0);
      if (!m_ack) begin
        if (rx_available && rxn < DEPTH) begin
          m_rxq.push_back(rx_value);
          m_ack = 1'b1;
        end
      end else if (!rx_available) begin
        m_ack = 1'b0;
      end
      if (wr_en && addr == 2'd2) m_baud[7:0] = wdata;
      if (wr_en && addr == 2'd3) m_baud[11:8] = wdata[3:0];
    end
    #1;
    case (addr)
      2'd0:    e_rd = (m_rxq.size() > 0) ? m_rxq[0] : 8'h00;
      2'd1:    e_rd = {2'b00, m_ovf, (m_phase != 0), (m_rxq.size() == DEPTH),
                       (m_rxq.size() == 0), (m_txq.size() == DEPTH), (m_txq.size() == 0)};
      2'd2:    e_rd = m_baud[7:0];
      default: e_rd = {4'h0, m_baud[11:8]};
    endcase
    chk("model_start_tx", start_tx, (m_phase == 1));
    chk("model_tx_value", tx_value, m_txv);
    chk("model_rx_clear", rx_clear, m_ack);
    chk("model_irq", irq, (m_rxq.size() > 0));
    chk("model_baud", uart_baud_counter, m_baud);
    chk("model_rdata", rdata, e_rd);
  end

  // ---------------- engine models ----------------
  bit eng_stall = 1'b0;
  int tx_cnt = 0;
  logic [7:0] rx_src[$];

  always @(negedge clk) begin
    if (rst) begin
      tx_done = 1'b0;
      tx_cnt  = 0;
    end else if (tx_done) begin
      if (!start_tx) begin
        tx_done = 1'b0;
        tx_cnt  = 0;
      end
    end else if (start_tx && !eng_stall) begin
      tx_cnt++;
      if (tx_cnt >= 20) tx_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      rx_available = 1'b0;
    end else if (rx_available) begin
      if (rx_clear) begin
        rx_available = 1'b0;
        rx_src.delete(0);
      end
    end else if (!rx_clear && rx_src.size() > 0) begin
      rx_value     = rx_src[0];
      rx_available = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    addr  = a;
    rd_en = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] v);
    addr = a;
    #1 v = rdata;
  endtask

  task automatic wait_start(input logic lvl, input string name);
    int n = 0;
    while (start_tx !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, start_tx, lvl);
  endtask

  task automatic tx_expect(input logic [7:0] exp, input string name);
    wait_start(1'b0, {name, "_gap"});
    wait_start(1'b1, {name, "_launch"});
    chk(name, tx_value, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    peek(2'd1, v);
    chk("rst_status", v, 8'h05);
    chk("rst_baud", uart_baud_counter, 12'd51);
    chk("rst_start_tx", start_tx, 1'b0);
    chk("rst_tx_value", tx_value, 8'h00);
    chk("rst_rx_clear", rx_clear, 1'b0);
    chk("rst_irq", irq, 1'b0);
    peek(2'd0, v);
    chk("rst_data", v, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // TX order and write-to-launch latency
    wr(2'd0, 8'hA5);
    chk("launch_not_at_e0", start_tx, 1'b0);
    wr(2'd0, 8'h3C);
    chk("launch_at_e1", start_tx, 1'b1);
    chk("launch_value_a5", tx_value, 8'hA5);
    tx_expect(8'h3C, "tx_second_3c");
    wait_start(1'b0, "tx_second_done");
    repeat (4) @(negedge clk);
    peek(2'd1, v);
    chk("tx_idle_status", v, 8'h05);

    // reset while in flight
    wr(2'd2, 8'h10);
    chk("baud_pre_reset", uart_baud_counter, 12'h010);
    wr(2'd0, 8'h77);
    wait_start(1'b1, "mid_launch");
    repeat (3) @(negedge clk);
    addr = 2'd1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_start_tx", start_tx, 1'b0);
    chk("mid_rst_tx_value", tx_value, 8'h00);
    chk("mid_rst_baud", uart_baud_counter, 12'd51);
    chk("mid_rst_status", rdata, 8'h05);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // TX overflow with a stalled engine
    eng_stall = 1'b1;
    for (int i = 0; i < 6; i++) wr(2'd0, 8'hB0 + 8'(i));
    chk("ovf_inflight", tx_value, 8'hB0);
    peek(2'd1, v);
    chk("ovf_status", v, 8'h36);
    wr(2'd1, 8'h20);
    peek(2'd1, v);
    chk("ovf_cleared_status", v, 8'h16);
    eng_stall = 1'b0;
    tx_expect(8'hB1, "ovf_drain_b1");
    tx_expect(8'hB2, "ovf_drain_b2");
    tx_expect(8'hB3, "ovf_drain_b3");
    tx_expect(8'hB4, "ovf_drain_b4");
    wait_start(1'b0, "ovf_drain_done");
    repeat (4) @(negedge clk);
    peek(2'd1, v);
    chk("ovf_final_status", v, 8'h05);

    // RX flow control
    for (int i = 0; i < 5; i++) rx_src.push_back(8'h11 + 8'(i));
    repeat (20) @(negedge clk);
    peek(2'd1, v);
    chk("rx_full_status", v, 8'h09);
    chk("rx_full_irq", irq, 1'b1);
    chk("rx_held_clear", rx_clear, 1'b0);
    chk("rx_held_avail", rx_available, 1'b1);
    chk("rx_held_value", rx_value, 8'h15);
    rd(2'd0, v);
    chk("rx_rd_11", v, 8'h11);
    repeat (4) @(negedge clk);
    peek(2'd1, v);
    chk("rx_refill_status", v, 8'h09);
    for (int i = 1; i < 5; i++) begin
      rd(2'd0, v);
      chk("rx_rd_seq", v, 8'h11 + 8'(i));
    end
    peek(2'd1, v);
    chk("rx_drained_status", v, 8'h05);
    chk("rx_drained_irq", irq, 1'b0);

    // simultaneous pop and push with two entries
    rx_src.push_back(8'h21);
    rx_src.push_back(8'h22);
    repeat (8) @(negedge clk);
    peek(2'd1, v);
    chk("sim_two_status", v, 8'h01);
    rx_src.push_back(8'h23);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!rx_available && n < 20);
    chk("sim_avail_seen", rx_available, 1'b1);
    rd(2'd0, v);
    chk("sim_rd_21", v, 8'h21);
    peek(2'd1, v);
    chk("sim_count_kept", v, 8'h01);
    rd(2'd0, v);
    chk("sim_rd_22", v, 8'h22);
    rd(2'd0, v);
    chk("sim_rd_23", v, 8'h23);
    peek(2'd1, v);
    chk("empty_status_before", v, 8'h05);
    rd(2'd0, v);
    chk("empty_rd_zero", v, 8'h00);
    peek(2'd1, v);
    chk("empty_status_after", v, 8'h05);

    // baud divisor
    wr(2'd2, 8'h34);
    wr(2'd3, 8'hF2);
    chk("baud_value", uart_baud_counter, 12'h234);
    peek(2'd3, v);
    chk("baud_hi_read", v, 8'h02);
    peek(2'd2, v);
    chk("baud_lo_read", v, 8'h34);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
